// File: rtl/msg_store_if.sv
// Writer/marquee-facing bundle of msg_store: byte write handshake plus scroll-step read side.
interface msg_store_if #(
    parameter int DEPTH = 32
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [7:0]      wr_data;
    logic            wr_valid;
    logic            wr_ready;
    logic            wr_ovf;
    logic            rd_next;
    logic [7:0]      rd_char;
    logic            rd_wrap;
    logic [ADDR_W:0] msg_len;

    modport master (
        output wr_data, wr_valid, rd_next,
        input  wr_ready, wr_ovf, rd_char, rd_wrap, msg_len
    );

    modport slave (
        input  wr_data, wr_valid, rd_next,
        output wr_ready, wr_ovf, rd_char, rd_wrap, msg_len
    );
endinterface

// File: rtl/msg_store.sv
// Double-buffered message store: writer fills the pending bank, marquee scrolls the active bank.
// Optional MSG_STORE_DEFAULT_EN preloads " HELLO \n" into the active bank at reset (needs DEPTH >= 8).
module msg_store #(
    parameter int DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    msg_store_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);
`ifdef MSG_STORE_DEFAULT_EN
    localparam logic [ADDR_W:0] DEF_LEN = (DEPTH >= 8) ? (ADDR_W+1)'(8) : (ADDR_W+1)'(0);
`else
    localparam logic [ADDR_W:0] DEF_LEN = {(ADDR_W+1){1'b0}};
`endif

    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} wstate_t;

    logic [7:0]        mem_r [2][DEPTH];
    wstate_t           state_r, state_s;
    logic [ADDR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [ADDR_W:0]   pend_len_r, msg_len_r, last_idx_s;
    logic              bank_sel_r, pend_sel_s;
    logic [7:0]        rd_char_r, store_byte_s;
    logic              rd_wrap_r, wr_ovf_r, wr_ready_r;
    logic              accept_s, is_nl_s, last_slot_s, ovf_s, wrap_s, swap_s;

    function automatic logic [7:0] hello_byte(input int idx);
        case (idx)
            0:       hello_byte = 8'h20;
            1:       hello_byte = 8'h48;
            2:       hello_byte = 8'h45;
            3:       hello_byte = 8'h4C;
            4:       hello_byte = 8'h4C;
            5:       hello_byte = 8'h4F;
            6:       hello_byte = 8'h20;
            7:       hello_byte = 8'h0A;
            default: hello_byte = 8'h20;
        endcase
    endfunction

    // Write FSM next state, terminator/overflow handling and read wrap/swap decode
    always_comb begin
        accept_s     = bus.wr_valid && (state_r == FILL);
        is_nl_s      = (bus.wr_data == 8'h0A);
        last_slot_s  = (wr_ptr_r == ADDR_W'(DEPTH - 1));
        pend_sel_s   = ~bank_sel_r;
        store_byte_s = bus.wr_data;
        ovf_s        = 1'b0;
        state_s      = state_r;
        last_idx_s   = msg_len_r - (ADDR_W+1)'(1);
        // An empty active bank wraps on every step, so a pending message is picked up at once.
        wrap_s = bus.rd_next &&
                 ((msg_len_r == {(ADDR_W+1){1'b0}}) || ({1'b0, rd_ptr_r} == last_idx_s));
        swap_s = wrap_s && (state_r == HOLD);
        case (state_r)
            FILL: begin
                if (accept_s && (is_nl_s || last_slot_s)) begin
                    state_s = HOLD;
                    if (!is_nl_s) begin
                        store_byte_s = 8'h0A;
                        ovf_s        = 1'b1;
                    end else begin
                        ovf_s        = 1'b0;
                    end
                end else begin
                    state_s = FILL;
                end
            end
            HOLD: begin
                if (swap_s) begin
                    state_s = FILL;
                end else begin
                    state_s = HOLD;
                end
            end
            default: state_s = FILL;
        endcase
    end

    // Bank storage: pending bank written by the writer, optional greeting preload
    always_ff @(posedge clk) begin
`ifdef MSG_STORE_DEFAULT_EN
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                if (i < DEPTH) begin
                    mem_r[0][i[ADDR_W-1:0]] <= hello_byte(i);
                end
            end
        end else
`endif
        if (accept_s) begin
            mem_r[pend_sel_s][wr_ptr_r] <= store_byte_s;
        end
    end

    // Control state: write FSM, pointers, bank select and pulse outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= FILL;
            wr_ptr_r   <= {ADDR_W{1'b0}};
            rd_ptr_r   <= {ADDR_W{1'b0}};
            pend_len_r <= {(ADDR_W+1){1'b0}};
            msg_len_r  <= DEF_LEN;
            bank_sel_r <= 1'b0;
            rd_wrap_r  <= 1'b0;
            wr_ovf_r   <= 1'b0;
            wr_ready_r <= 1'b1;
        end else begin
            state_r    <= state_s;
            wr_ready_r <= (state_s == FILL);
            wr_ovf_r   <= ovf_s;
            rd_wrap_r  <= wrap_s;
            if (swap_s) begin
                wr_ptr_r <= {ADDR_W{1'b0}};
            end else if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
            end
            if (accept_s) begin
                pend_len_r <= {1'b0, wr_ptr_r} + (ADDR_W+1)'(1);
            end
            if (wrap_s) begin
                rd_ptr_r <= {ADDR_W{1'b0}};
            end else if (bus.rd_next) begin
                rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
            end
            if (swap_s) begin
                bank_sel_r <= ~bank_sel_r;
                msg_len_r  <= pend_len_r;
            end
        end
    end

    // Registered character out of the active bank; blank when nothing is active
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_char_r <= 8'h20;
        end else if (msg_len_r == {(ADDR_W+1){1'b0}}) begin
            rd_char_r <= 8'h20;
        end else begin
            rd_char_r <= mem_r[bank_sel_r][rd_ptr_r];
        end
    end

    assign bus.wr_ready = wr_ready_r;
    assign bus.wr_ovf   = wr_ovf_r;
    assign bus.rd_char  = rd_char_r;
    assign bus.rd_wrap  = rd_wrap_r;
    assign bus.msg_len  = msg_len_r;
endmodule

// File: tb/tb_msg_store.sv
// Scoreboard bench for msg_store: DEPTH=32 scroll/swap scenarios and a DEPTH=4 overflow case.
module tb_msg_store;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    msg_store_if #(.DEPTH(32)) b  ();
    msg_store_if #(.DEPTH(4))  b4 ();

    msg_store #(.DEPTH(32)) u32 (.clk(clk), .rst(rst), .bus(b.slave));
    msg_store #(.DEPTH(4))  u4  (.clk(clk), .rst(rst), .bus(b4.slave));

    typedef struct {
        logic [7:0] ch;
        logic       wrap;
        logic [5:0] len;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic fired_r = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one scroll step on the DEPTH=32 store and queue its expected outcome.
    task automatic rd(input logic [7:0] ch, input logic wrap, input logic [5:0] len);
        exp_t e;
        e.ch = ch; e.wrap = wrap; e.len = len;
        exp_q.push_back(e);
        b.rd_next = 1'b1;
        @(negedge clk);
        b.rd_next = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d);
        int n;
        n = 0;
        b.wr_data  = d;
        b.wr_valid = 1'b1;
        while (b.wr_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n == 40) chk("wr_timeout", 32'(n), 32'd0);
        @(negedge clk);
        b.wr_valid = 1'b0;
    endtask

    task automatic wr_str(input string s);
        for (int i = 0; i < s.len(); i++) wr(s[i]);
    endtask

    always @(posedge clk) fired_r <= b.rd_next;

    // Monitor: wrap/len are due right after the step edge, the character one cycle later.
    initial begin
        exp_t mid;
        exp_t e;
        logic due;
        due = 1'b0;
        forever begin
            @(negedge clk);
            if (due) begin
                chk("rd_char", 32'(b.rd_char), 32'(mid.ch));
                due = 1'b0;
            end
            if (fired_r === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_wrap", 32'(b.rd_wrap), 32'(e.wrap));
                    chk("msg_len", 32'(b.msg_len), 32'(e.len));
                    mid = e;
                    due = 1'b1;
                end
            end else begin
                chk("rd_wrap_idle", 32'(b.rd_wrap), 32'd0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ovf_bytes [5];
        logic [7:0] ovf_read [4];
        string hello;
        ovf_bytes = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        ovf_read  = '{8'h41, 8'h42, 8'h43, 8'h0A};
        hello     = " HELLO \n";
        rst = 1'b1;
        b.wr_data = 8'h00;  b.wr_valid = 1'b0;  b.rd_next = 1'b0;
        b4.wr_data = 8'h00; b4.wr_valid = 1'b0; b4.rd_next = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_rd_char", 32'(b.rd_char), 32'h20);
        chk("rst_wr_ready", 32'(b.wr_ready), 32'd1);
        chk("rst_wr_ovf", 32'(b.wr_ovf), 32'd0);
        chk("rst4_msg_len", 32'(b4.msg_len), 32'd0);
`ifdef MSG_STORE_DEFAULT_EN
        chk("rst_msg_len_def", 32'(b.msg_len), 32'd8);
        wr(8'h51); wr(8'h51);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midfill_wr_ready", 32'(b.wr_ready), 32'd1);
        chk("midfill_msg_len", 32'(b.msg_len), 32'd8);
        chk("midfill_rd_char", 32'(b.rd_char), 32'h20);
        for (int i = 1; i < 8; i++) rd(hello[i], 1'b0, 6'd8);
        rd(8'h20, 1'b1, 6'd8);
        // Discarded "QQ" must not lengthen the next message.
        wr_str("Z\n");
        for (int i = 1; i < 8; i++) rd(hello[i], 1'b0, 6'd8);
        rd(8'h5A, 1'b1, 6'd2);
`else
        chk("rst_msg_len", 32'(b.msg_len), 32'd0);
        repeat (3) rd(8'h20, 1'b1, 6'd0);
        wr_str("AB\n");
        chk("hold_wr_ready", 32'(b.wr_ready), 32'd0);
        chk("ab_wr_ovf", 32'(b.wr_ovf), 32'd0);
        rd(8'h41, 1'b1, 6'd3);
        chk("swap_wr_ready", 32'(b.wr_ready), 32'd1);
        rd(8'h42, 1'b0, 6'd3);
        rd(8'h0A, 1'b0, 6'd3);
        rd(8'h41, 1'b1, 6'd3);
        wr_str("XYZ\n");
        chk("xyz_wr_ready", 32'(b.wr_ready), 32'd0);
        rd(8'h42, 1'b0, 6'd3);
        chk("xyz_still_hold", 32'(b.wr_ready), 32'd0);
        rd(8'h0A, 1'b0, 6'd3);
        rd(8'h58, 1'b1, 6'd4);
        chk("xyz_swap_ready", 32'(b.wr_ready), 32'd1);
        rd(8'h59, 1'b0, 6'd4);
        rd(8'h5A, 1'b0, 6'd4);
        rd(8'h0A, 1'b0, 6'd4);
        rd(8'h58, 1'b1, 6'd4);
        rd(8'h59, 1'b0, 6'd4);
        rd(8'h5A, 1'b0, 6'd4);
        rd(8'h0A, 1'b0, 6'd4);
        // Terminator accepted on the same edge as a wrapping step: that wrap must not swap.
        fork
            wr_str("K\n");
            begin
                @(negedge clk);
                rd(8'h58, 1'b1, 6'd4);
            end
        join
        chk("same_edge_hold", 32'(b.wr_ready), 32'd0);
        rd(8'h59, 1'b0, 6'd4);
        rd(8'h5A, 1'b0, 6'd4);
        rd(8'h0A, 1'b0, 6'd4);
        rd(8'h4B, 1'b1, 6'd2);
        chk("k_swap_ready", 32'(b.wr_ready), 32'd1);
        rd(8'h0A, 1'b0, 6'd2);
        rd(8'h4B, 1'b1, 6'd2);
`endif
        // DEPTH=4 overflow: "ABCDE" keeps A,B,C and forces the terminator into slot 3.
        b4.wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b4.wr_data = ovf_bytes[i];
            @(negedge clk);
        end
        chk("ovf_pulse", 32'(b4.wr_ovf), 32'd1);
        chk("ovf_wr_ready", 32'(b4.wr_ready), 32'd0);
        b4.wr_data = ovf_bytes[4];
        @(negedge clk);
        chk("ovf_one_cycle", 32'(b4.wr_ovf), 32'd0);
        chk("ovf_stall", 32'(b4.wr_ready), 32'd0);
        chk("ovf_len_before", 32'(b4.msg_len), 32'd0);
        b4.rd_next = 1'b1;
        @(negedge clk);
        b4.rd_next = 1'b0;
        chk("ovf_msg_len", 32'(b4.msg_len), 32'd4);
        chk("ovf_swap_wrap", 32'(b4.rd_wrap), 32'd1);
        chk("ovf_ready_back", 32'(b4.wr_ready), 32'd1);
        @(negedge clk);
        b4.wr_valid = 1'b0;
        chk("ovf_char0", 32'(b4.rd_char), 32'(ovf_read[0]));
        for (int j = 1; j < 4; j++) begin
            b4.rd_next = 1'b1;
            @(negedge clk);
            b4.rd_next = 1'b0;
            @(negedge clk);
            chk("ovf_char", 32'(b4.rd_char), 32'(ovf_read[j]));
        end
        b4.rd_next = 1'b1;
        @(negedge clk);
        b4.rd_next = 1'b0;
        chk("ovf_wrap", 32'(b4.rd_wrap), 32'd1);
        repeat (3) @(negedge clk);
        chk("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/msg_store.md
# msg_store

Double-buffered message store upstream of the scrolling marquee stage. A byte writer, such as a UART receiver, fills a pending bank with one '\n'-terminated message. The marquee pulls characters one per scroll step from the active bank. Banks swap only at the active message's wrap point, so the display never shows a half-written message.

## Interface
- DEPTH, 32: bytes per bank; power of two, ≥4; ADDR_W = log2(DEPTH)
- clk  in  1  system clock (internal oscillator domain)
- rst  in  1  synchronous, active-high reset
- wr_data  in  8  ASCII byte from writer
- wr_valid  in  1  writer offers wr_data
- wr_ready  out  1  store accepts; transfer occurs when wr_valid & wr_ready at posedge
- wr_ovf  out  1  one-cycle pulse: message truncated at DEPTH
- rd_next  in  1  one-cycle advance request from marquee, one per scroll step
- rd_char  out  8  current character of active message (registered)
- rd_wrap  out  1  one-cycle pulse: read pointer wrapped to index 0
- msg_len  out  ADDR_W+1  length of active message including '\n'; 0 = empty

## Operation
- Storage: two banks of DEPTH×8 registers. bank_sel selects active; the other bank is pending.
- Write FSM, states FILL and HOLD:
  - FILL: wr_ready=1. Each accepted byte goes to pending[wr_ptr]; wr_ptr increments.
  - Accepted byte == 8'h0A: store it, latch pend_len = wr_ptr+1, go HOLD.
  - Accepted byte at wr_ptr == DEPTH-1 and not '\n': store 8'h0A instead, pend_len = DEPTH, pulse wr_ovf, go HOLD.
  - HOLD: wr_ready=0. Wait for swap; on swap go FILL with wr_ptr=0.
- Read side, rd_ptr into active bank; rd_char = active[rd_ptr] registered.
  - rd_next with rd_ptr < msg_len-1: rd_ptr+1.
  - rd_next with rd_ptr == msg_len-1 (terminator), or msg_len == 0: rd_ptr=0, pulse rd_wrap. If write FSM is HOLD in that cycle, swap: bank_sel toggles, msg_len = pend_len.
- Empty active bank (msg_len=0): rd_char = 8'h20.
- A message consisting only of "\n" is legal: msg_len=1.
- Reset values: rd_char=8'h20, rd_wrap=0, wr_ovf=0, wr_ready=1 from first cycle after reset, msg_len=0, rd_ptr=0, wr_ptr=0, bank_sel=0, FSM=FILL. Bank contents are not cleared except per Configuration.
- Reset mid-fill discards the partial pending message. Reset in HOLD discards the completed pending message.

## Timing
- rd_char reflects a rd_next effect one cycle later. rd_wrap and swap are registered in the same edge as rd_ptr.
- wr_ready drops the cycle after the terminating byte is accepted. It rises the cycle after the swap edge.
- A terminator commit at edge t makes HOLD visible at t+1. rd_next wrapping in cycle t does not swap; the next wrap does.
- After a swap, rd_char is the new bank's index 0 one cycle later.
- rd_next asserted on consecutive cycles advances once per cycle. No back-pressure on the read side.
- Throughput: one write per cycle in FILL.

## Configuration
- MSG_STORE_DEFAULT_EN defined: reset loads active bank with " HELLO \n" (8 bytes), msg_len=8, rd_char=8'h20.
- Not defined: active bank empty after reset, as above.

## Test plan
- Reset, no defines; pulse rd_next 3× -> rd_char stays 8'h20, rd_wrap pulses each time, msg_len=0.
- Write "AB\n" -> wr_ready low after '\n'. Next rd_next swaps: msg_len=3. Subsequent rd_next sequence gives 'A','B',8'h0A,'A', with rd_wrap on the step after 8'h0A.
- With "AB\n" active, write "XYZ\n" while reading:
  - No swap until rd_ptr passes 8'h0A; then 'X' appears.
  - wr_ready returns high the cycle after the swap.
- DEPTH=4, write "ABCDE" -> bytes 'A','B','C' stored, 4th stored as 8'h0A. wr_ovf pulses once, 'E' is stalled by wr_ready=0, msg_len=4 after swap.
- Terminator accepted in the same cycle as a wrapping rd_next -> no swap that cycle; swap on the following wrap.
- MSG_STORE_DEFAULT_EN defined; assert rst mid-fill of "QQ" -> after reset wr_ready=1, msg_len=8, rd_next sequence gives ' ','H','E','L','L','O',' ',8'h0A.
